// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit and the control unit.
//   - load (mem_read) and store (mem_write) operation codes
//   - FSM state encoding and access-size classification
//   - default bus timeout and small decode helpers
package mem_access_unit_pkg;

    // Load codes driven by the control unit on mem_read (110/111 decode as none).
    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_LW   = 3'b001;
    localparam logic [2:0] LD_LH   = 3'b010;
    localparam logic [2:0] LD_LHU  = 3'b011;
    localparam logic [2:0] LD_LB   = 3'b100;
    localparam logic [2:0] LD_LBU  = 3'b101;

    // Store codes driven by the control unit on mem_write.
    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_SW   = 2'b01;
    localparam logic [1:0] ST_SH   = 2'b10;
    localparam logic [1:0] ST_SB   = 2'b11;

    // Maximum number of BUSY cycles spent waiting for mem_ready.
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    function automatic logic is_load(input logic [2:0] code);
        return (code >= LD_LW) && (code <= LD_LBU);
    endfunction

    function automatic size_e load_size(input logic [2:0] code);
        case (code)
            LD_LW:          return SZ_WORD;
            LD_LH, LD_LHU:  return SZ_HALF;
            default:        return SZ_BYTE;
        endcase
    endfunction

    function automatic size_e store_size(input logic [1:0] code);
        case (code)
            ST_SW:   return SZ_WORD;
            ST_SH:   return SZ_HALF;
            default: return SZ_BYTE;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_WORD: return off != 2'b00;
            SZ_HALF: return off[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-result formatter.
// Ports:
//   rdata_i [31:0] - raw word returned by memory
//   op_i    [2:0]  - load code (LW/LH/LHU/LB/LBU; anything else yields 0)
//   off_i   [1:0]  - byte offset of the access inside the word
//   data_o  [31:0] - lane-selected, sign/zero-extended load result
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  op_i,
    input  logic [1:0]  off_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (op_i)
            LD_LW:   data_o = rdata_i;
            LD_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  data_o = {16'h0000, half_sel};
            LD_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  data_o = {24'h000000, byte_sel};
            default: data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the core pipeline and a word-wide memory bus.
// Decodes the control unit's load/store codes, rejects misaligned accesses,
// runs a request/ready handshake with a bounded wait, and returns a one-cycle
// done pulse with the extended load result.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   mem_read [2:0]           - load code (load wins over a simultaneous store)
//   mem_write[1:0]           - store code
//   addr, store_data [31:0]  - byte address and rs2 value
//   load_data [31:0]         - extended load result, valid while done=1
//   stall                    - hold-PC request to the core
//   done, misaligned, bus_error - one-cycle completion pulse and its status
//   mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata - memory request (held while BUSY)
//   mem_ready, mem_rdata     - memory response
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  mem_read,
    input  logic [1:0]  mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        done,
    output logic        misaligned,
    output logic        bus_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        ld_code_q, ld_code_d;
    logic [1:0]        st_code_q, st_code_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       sdata_q, sdata_d;
    logic [31:0]       ld_data_q, ld_data_d;
    logic              misal_q, misal_d;
    logic              berr_q, berr_d;

    logic              load_req, store_req, acc_req, req_misal;
    size_e             req_size;
    logic [31:0]       ext_data;
    logic [3:0]        strb_w;
    logic [31:0]       wdata_w;
    logic              busy, is_store;

    // Request decode on the live instruction inputs.
    always_comb begin
        load_req  = is_load(mem_read);
        store_req = !load_req && (mem_write != ST_NONE);
        acc_req   = load_req || store_req;
        req_size  = load_req ? load_size(mem_read) : store_size(mem_write);
        req_misal = is_misaligned(req_size, addr[1:0]);
    end

    load_extend u_load_extend (
        .rdata_i (mem_rdata),
        .op_i    (ld_code_q),
        .off_i   (addr_q[1:0]),
        .data_o  (ext_data)
    );

    // Store lane strobes and lane-replicated data from the latched request.
    always_comb begin
        strb_w  = 4'b0000;
        wdata_w = 32'h0000_0000;
        case (st_code_q)
            ST_SW: begin
                strb_w  = 4'b1111;
                wdata_w = sdata_q;
            end
            ST_SH: begin
                strb_w  = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_w = {2{sdata_q[15:0]}};
            end
            ST_SB: begin
                strb_w  = 4'b0001 << addr_q[1:0];
                wdata_w = {4{sdata_q[7:0]}};
            end
            ST_NONE: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ld_code_q <= LD_NONE;
            st_code_q <= ST_NONE;
            addr_q    <= '0;
            sdata_q   <= '0;
            ld_data_q <= '0;
            misal_q   <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_code_q <= ld_code_d;
            st_code_q <= st_code_d;
            addr_q    <= addr_d;
            sdata_q   <= sdata_d;
            ld_data_q <= ld_data_d;
            misal_q   <= misal_d;
            berr_q    <= berr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_code_d = ld_code_q;
        st_code_d = st_code_q;
        addr_d    = addr_q;
        sdata_d   = sdata_q;
        ld_data_d = ld_data_q;
        misal_d   = misal_q;
        berr_d    = berr_q;
        case (state_q)
            S_IDLE: begin
                if (acc_req) begin
                    if (req_misal) begin
                        // Reported straight away; memory is never touched.
                        misal_d   = 1'b1;
                        ld_data_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        ld_code_d = load_req ? mem_read : LD_NONE;
                        st_code_d = load_req ? ST_NONE : mem_write;
                        addr_d    = addr;
                        sdata_d   = store_data;
                        cnt_d     = '0;
                        state_d   = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // mem_ready takes priority over a timeout in the same cycle.
                if (mem_ready) begin
                    ld_data_d = ext_data;
                    state_d   = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    berr_d    = 1'b1;
                    ld_data_d = '0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                // Status only lives for the single DONE cycle.
                ld_data_d = '0;
                misal_d   = 1'b0;
                berr_d    = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == S_BUSY);
        is_store = (st_code_q != ST_NONE);
        case (state_q)
            S_IDLE:  stall = acc_req;
            S_BUSY:  stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    assign mem_req    = busy;
    assign mem_we     = busy && is_store;
    assign mem_addr   = busy ? {addr_q[31:2], 2'b00} : 32'h0000_0000;
    assign mem_wstrb  = (busy && is_store) ? strb_w : 4'b0000;
    assign mem_wdata  = (busy && is_store) ? wdata_w : 32'h0000_0000;
    assign done       = (state_q == S_DONE);
    assign misaligned = misal_q;
    assign bus_error  = berr_q;
    assign load_data  = ld_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mem_read;
    logic [1:0]  mem_write;
    logic [31:0] addr, store_data, load_data;
    logic        stall, done, misaligned, bus_error;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int vectors = 0;
    int miscompares = 0;

    // Observations collected by run_access for the scenario tasks to judge.
    int          o_lat;
    logic        o_req_seen, o_we, o_mis, o_be, o_stable, o_stall0, o_done_after;
    logic [31:0] o_addr, o_wdata, o_ld;
    logic [3:0]  o_strb;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .store_data (store_data),
        .load_data  (load_data),
        .stall      (stall),
        .done       (done),
        .misaligned (misaligned),
        .bus_error  (bus_error),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    // Presents one instruction (starting 1 time unit after a rising edge) and
    // plays the memory side: mem_ready is raised during BUSY cycle ready_at
    // (1-based; 0 = never). Records what the DUT did; judges nothing.
    task automatic run_access(input logic [2:0] rd, input logic [1:0] wr,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] rdat, input int ready_at);
        int busy_n = 0;
        o_lat = -1; o_req_seen = 0; o_we = 0; o_mis = 0; o_be = 0; o_stable = 1;
        o_addr = 0; o_wdata = 0; o_ld = 0; o_strb = 0; o_done_after = 0;
        mem_read = rd; mem_write = wr; addr = a; store_data = sd; mem_rdata = rdat;
        mem_ready = (ready_at == 1);
        #1 o_stall0 = stall;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            if (mem_req) begin
                busy_n++;
                if (!o_req_seen) begin
                    o_req_seen = 1; o_addr = mem_addr; o_we = mem_we;
                    o_strb = mem_wstrb; o_wdata = mem_wdata;
                end else if (mem_addr !== o_addr || mem_we !== o_we ||
                             mem_wstrb !== o_strb || mem_wdata !== o_wdata) begin
                    o_stable = 0;
                end
                mem_ready = (busy_n == ready_at);
            end else begin
                mem_ready = 0;
            end
            if (done === 1'b1) begin
                o_lat = cyc; o_ld = load_data; o_mis = misaligned; o_be = bus_error;
                mem_read = 0; mem_write = 0; mem_ready = 0;
                break;
            end
        end
        mem_read = 0; mem_write = 0; mem_ready = 0;
        @(posedge clk); #1;
        o_done_after = done;
    endtask

    // Reference load result from plain shifting/masking arithmetic.
    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] code, input int off);
        logic [31:0] sh, v;
        sh = w >> (8 * off);
        case (code)
            3'd1: v = w;
            3'd2: begin v = sh % 32'd65536; if (v >= 32'd32768) v = v - 32'd65536; end
            3'd3: v = sh % 32'd65536;
            3'd4: begin v = sh % 32'd256; if (v >= 32'd128) v = v - 32'd256; end
            3'd5: v = sh % 32'd256;
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic test_reset();
        rst = 1; mem_read = 0; mem_write = 0; addr = 0; store_data = 0;
        mem_ready = 0; mem_rdata = 0;
        @(posedge clk); #1;
        vectors++;
        if ({load_data, done, misaligned, bus_error, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, stall} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ld=%h done=%b mis=%b be=%b req=%b we=%b addr=%h strb=%b wd=%h stall=%b, want all 0",
                     load_data, done, misaligned, bus_error, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, stall);
        end
        mem_read = 3'b001; #1;
        vectors++;
        if (stall !== 1'b1) begin miscompares++; $display("FAIL reset_stall_follows_req: got %b want 1", stall); end
        @(posedge clk); #1;
        vectors++;
        if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_no_req: got %b want 0", mem_req); end
        mem_read = 0; #1 rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw_basic();
        run_access(3'b001, 2'b00, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        vectors++; if (o_lat !== 2) begin miscompares++; $display("FAIL lw_latency: got %0d want 2", o_lat); end
        vectors++; if (o_addr !== 32'h100) begin miscompares++; $display("FAIL lw_addr: got %h want 00000100", o_addr); end
        vectors++; if (o_strb !== 4'b0000 || o_we !== 1'b0) begin miscompares++; $display("FAIL lw_strb_we: got %b/%b want 0000/0", o_strb, o_we); end
        vectors++; if (o_ld !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw_data: got %h want deadbeef", o_ld); end
        vectors++; if (o_done_after !== 1'b0) begin miscompares++; $display("FAIL lw_done_one_cycle: got %b want 0", o_done_after); end
    endtask

    task automatic test_lb_lbu();
        run_access(3'b100, 2'b00, 32'h103, 32'h0, 32'h80FF7F01, 1);
        vectors++; if (o_ld !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb_data: got %h want ffffff80", o_ld); end
        run_access(3'b101, 2'b00, 32'h103, 32'h0, 32'h80FF7F01, 1);
        vectors++; if (o_ld !== 32'h00000080) begin miscompares++; $display("FAIL lbu_data: got %h want 00000080", o_ld); end
        vectors++; if (o_addr !== 32'h100) begin miscompares++; $display("FAIL lbu_addr: got %h want 00000100", o_addr); end
    endtask

    task automatic test_sh();
        run_access(3'b000, 2'b10, 32'h202, 32'h1234ABCD, 32'h0, 1);
        vectors++; if (o_addr !== 32'h200) begin miscompares++; $display("FAIL sh_addr: got %h want 00000200", o_addr); end
        vectors++; if (o_strb !== 4'b1100) begin miscompares++; $display("FAIL sh_strb: got %b want 1100", o_strb); end
        vectors++; if (o_wdata !== 32'hABCDABCD) begin miscompares++; $display("FAIL sh_wdata: got %h want abcdabcd", o_wdata); end
        vectors++; if (o_we !== 1'b1) begin miscompares++; $display("FAIL sh_we: got %b want 1", o_we); end
        vectors++; if (o_lat !== 2) begin miscompares++; $display("FAIL sh_latency: got %0d want 2", o_lat); end
        // Load and store together: the load wins, nothing is written.
        run_access(3'b001, 2'b01, 32'h10, 32'hFFFFFFFF, 32'h13572468, 1);
        vectors++; if (o_we !== 1'b0 || o_ld !== 32'h13572468) begin miscompares++; $display("FAIL load_wins: got we=%b ld=%h want we=0 ld=13572468", o_we, o_ld); end
    endtask

    task automatic test_misaligned();
        run_access(3'b001, 2'b00, 32'h101, 32'h0, 32'hDEADBEEF, 1);
        vectors++; if (o_req_seen !== 1'b0) begin miscompares++; $display("FAIL mis_no_req: got %b want 0", o_req_seen); end
        vectors++; if (o_lat !== 1) begin miscompares++; $display("FAIL mis_latency: got %0d want 1", o_lat); end
        vectors++; if (o_mis !== 1'b1 || o_be !== 1'b0) begin miscompares++; $display("FAIL mis_flags: got mis=%b be=%b want 1/0", o_mis, o_be); end
        vectors++; if (o_ld !== 32'h0) begin miscompares++; $display("FAIL mis_data: got %h want 00000000", o_ld); end
        run_access(3'b000, 2'b01, 32'h102, 32'h55AA55AA, 32'h0, 1);
        vectors++; if (o_req_seen !== 1'b0 || o_mis !== 1'b1) begin miscompares++; $display("FAIL mis_store: got req=%b mis=%b want 0/1", o_req_seen, o_mis); end
    endtask

    task automatic test_timeout();
        run_access(3'b010, 2'b00, 32'h40, 32'h0, 32'h1234F00D, 0);
        vectors++; if (o_lat !== TO + 1) begin miscompares++; $display("FAIL to_latency: got %0d want %0d", o_lat, TO + 1); end
        vectors++; if (o_be !== 1'b1 || o_ld !== 32'h0) begin miscompares++; $display("FAIL to_error: got be=%b ld=%h want 1/00000000", o_be, o_ld); end
        run_access(3'b010, 2'b00, 32'h40, 32'h0, 32'h1234F00D, TO);
        vectors++; if (o_lat !== TO + 1) begin miscompares++; $display("FAIL to_ready_latency: got %0d want %0d", o_lat, TO + 1); end
        vectors++; if (o_be !== 1'b0 || o_ld !== 32'hFFFFF00D) begin miscompares++; $display("FAIL to_ready_wins: got be=%b ld=%h want 0/fffff00d", o_be, o_ld); end
    endtask

    task automatic test_reset_busy();
        logic done_seen = 0;
        mem_read = 3'b001; addr = 32'h300; mem_ready = 0; mem_rdata = 32'h0;
        @(posedge clk); #1;
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rb_busy_req: got %b want 1", mem_req); end
        @(posedge clk); #2;
        rst = 1; #1;
        vectors++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin miscompares++; $display("FAIL rb_abort: got req=%b addr=%h want 0/00000000", mem_req, mem_addr); end
        mem_read = 0; #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rb_idle_stall: got %b want 0", stall); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            done_seen = done_seen | done;
        end
        rst = 0;
        @(posedge clk); #1;
        done_seen = done_seen | done;
        vectors++; if (done_seen !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL rb_no_done: got done=%b req=%b want 0/0", done_seen, mem_req); end
        run_access(3'b001, 2'b00, 32'h304, 32'h0, 32'hCAFEF00D, 2);
        vectors++; if (o_lat !== 3 || o_ld !== 32'hCAFEF00D) begin miscompares++; $display("FAIL rb_recover: got lat=%0d ld=%h want 3/cafef00d", o_lat, o_ld); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  rd;
            logic [1:0]  wr;
            logic [31:0] a, sd, rdat, e_ld, e_addr, e_wdata;
            logic [3:0]  e_strb;
            int          rdy, size, off, eff, e_lat;
            bit          is_ld, is_st, mis, e_be, e_we;
            do begin
                rd = 3'($urandom_range(0, 7));
                wr = 2'($urandom_range(0, 3));
                is_ld = (rd >= 1 && rd <= 5);
                is_st = !is_ld && (wr != 0);
            end while (!is_ld && !is_st);
            a = $urandom; sd = $urandom; rdat = $urandom;
            rdy = $urandom_range(0, TO + 2);

            if (is_ld) size = (rd == 1) ? 4 : ((rd <= 3) ? 2 : 1);
            else       size = (wr == 1) ? 4 : ((wr == 2) ? 2 : 1);
            off   = int'(a % 4);
            mis   = (off % size) != 0;
            eff   = (rdy >= 1 && rdy <= TO) ? rdy : 0;
            e_lat = mis ? 1 : ((eff != 0) ? 1 + eff : 1 + TO);
            e_be  = !mis && (eff == 0);
            e_ld  = (is_ld && !mis && !e_be) ? model_load(rdat, rd, off) : 32'h0;
            e_addr = mis ? 32'h0 : (a / 4) * 4;
            e_we   = is_st && !mis;
            e_strb = e_we ? 4'(((1 << size) - 1) << off) : 4'b0000;
            if (!e_we)          e_wdata = 32'h0;
            else if (size == 4) e_wdata = sd;
            else if (size == 2) e_wdata = (sd % 32'h10000) * 32'h00010001;
            else                e_wdata = (sd % 32'h100) * 32'h01010101;

            run_access(rd, wr, a, sd, rdat, rdy);
            vectors++; if (o_lat !== e_lat) begin miscompares++; $display("FAIL rnd%0d latency: got %0d want %0d", n, o_lat, e_lat); end
            vectors++; if (o_stall0 !== 1'b1) begin miscompares++; $display("FAIL rnd%0d idle_stall: got %b want 1", n, o_stall0); end
            vectors++; if (o_req_seen !== !mis) begin miscompares++; $display("FAIL rnd%0d req_seen: got %b want %b", n, o_req_seen, !mis); end
            vectors++; if (o_addr !== e_addr) begin miscompares++; $display("FAIL rnd%0d mem_addr: got %h want %h", n, o_addr, e_addr); end
            vectors++; if (o_we !== e_we) begin miscompares++; $display("FAIL rnd%0d mem_we: got %b want %b", n, o_we, e_we); end
            vectors++; if (o_strb !== e_strb) begin miscompares++; $display("FAIL rnd%0d wstrb: got %b want %b", n, o_strb, e_strb); end
            vectors++; if (o_wdata !== e_wdata) begin miscompares++; $display("FAIL rnd%0d wdata: got %h want %h", n, o_wdata, e_wdata); end
            vectors++; if (o_ld !== e_ld) begin miscompares++; $display("FAIL rnd%0d load_data: got %h want %h (rd=%0d a=%h rdata=%h)", n, o_ld, e_ld, rd, a, rdat); end
            vectors++; if (o_mis !== mis) begin miscompares++; $display("FAIL rnd%0d misaligned: got %b want %b", n, o_mis, mis); end
            vectors++; if (o_be !== e_be) begin miscompares++; $display("FAIL rnd%0d bus_error: got %b want %b", n, o_be, e_be); end
            vectors++; if (o_stable !== 1'b1) begin miscompares++; $display("FAIL rnd%0d req_stable: got %b want 1", n, o_stable); end
            vectors++; if (o_done_after !== 1'b0) begin miscompares++; $display("FAIL rnd%0d done_one_cycle: got %b want 0", n, o_done_after); end
        end
    endtask

    initial begin
        test_reset();
        test_lw_basic();
        test_lb_lbu();
        test_sh();
        test_misaligned();
        test_timeout();
        test_reset_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
